// File: rtl/set_bit_scanner_pkg.sv
// Shared types and bit-vector helpers for the set-bit scanner.
// Helpers work on a 64-bit zero-extended view so every legal WIDTH can share them.
package set_bit_scanner_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } scan_state_e;

  // Walks from the top down so the last hit is the lowest set index.
  function automatic int unsigned lowest_set(input logic [MAX_W-1:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

  function automatic logic popcount_is_one(input logic [MAX_W-1:0] vec);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_W; i++) begin
      n += 32'(vec[i]);
    end
    return (n == 1);
  endfunction

endpackage

// File: rtl/set_bit_prienc.sv
// Combinational lowest-set-bit encoder; index is 0 when no bit is set.
module set_bit_prienc
  import set_bit_scanner_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] index_o,
  output logic             any_o
);

  assign index_o = IDX_W'(lowest_set(MAX_W'(vec_i)));
  assign any_o   = |vec_i;

endmodule

// File: rtl/set_bit_scanner.sv
// Accepts a WIDTH-bit vector and streams the index of each set bit, lowest first,
// one per out handshake, then pulses done with the number of indices emitted.
module set_bit_scanner
  import set_bit_scanner_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             done,
  output logic [IDX_W:0]   count
);

  scan_state_e      state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] low_idx;
  logic             pend_any;
  logic             pend_one;

  set_bit_prienc #(.WIDTH(WIDTH)) u_prienc (
    .vec_i   (pend_q),
    .index_o (low_idx),
    .any_o   (pend_any)
  );

  assign pend_one = popcount_is_one(MAX_W'(pend_q));
  assign done     = done_q;
  assign count    = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_index = '0;
    out_last  = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          pend_d  = in_data;
          cnt_d   = '0;
          state_d = (in_data != '0) ? SCAN : FINISH;
        end
      end
      SCAN: begin
        out_valid = 1'b1;
        out_index = low_idx;
        out_last  = pend_one;
        if (out_ready) begin
          pend_d = pend_q & ~(WIDTH'(1) << low_idx);
          cnt_d  = cnt_q + (IDX_W+1)'(1);
          if (pend_one) state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // done/count are registered so they appear exactly in the FINISH cycle.
    done_d  = (state_d == FINISH);
    count_d = done_d ? cnt_d : '0;
  end

  always_comb begin
    if (state_q == SCAN) assert (pend_any);
  end

endmodule

// File: tb/tb_set_bit_scanner.sv
// Directed bench for set_bit_scanner: WIDTH=8 instance plus a WIDTH=5 instance.
module tb_set_bit_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_last, done;
  logic [7:0] in_data;
  logic [2:0] out_index;
  logic [3:0] count;

  logic       in_valid5, in_ready5, out_valid5, out_ready5, out_last5, done5;
  logic [4:0] in_data5;
  logic [2:0] out_index5;
  logic [3:0] count5;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  set_bit_scanner #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_last(out_last), .done(done), .count(count)
  );

  set_bit_scanner #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_index(out_index5),
    .out_last(out_last5), .done(done5), .count(count5)
  );

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; in_data = '0; out_ready = 0;
    in_valid5 = 0; in_data5 = '0; out_ready5 = 0;
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    n_cmp++; if (out_index !== 3'd0) begin n_bad++; $display("FAIL reset_out_index: got %0d want 0", out_index); end
    n_cmp++; if (done !== 1'b0 || count !== 4'd0) begin n_bad++; $display("FAIL reset_done_count: got %b/%0d want 0/0", done, count); end
    n_cmp++; if (in_ready5 !== 1'b1 || out_valid5 !== 1'b0) begin n_bad++; $display("FAIL reset_w5: got rdy %b vld %b want 1/0", in_ready5, out_valid5); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int exp_idx[4] = '{1, 2, 5, 7};
    in_valid = 1; in_data = 8'b1010_0110; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_index !== 3'(exp_idx[i]))
        begin n_bad++; $display("FAIL basic_idx[%0d]: got vld %b idx %0d want 1/%0d", i, out_valid, out_index, exp_idx[i]); end
      n_cmp++; if (out_last !== (i == 3))
        begin n_bad++; $display("FAIL basic_last[%0d]: got %b want %b", i, out_last, (i == 3)); end
      n_cmp++; if (in_ready !== 1'b0 || done !== 1'b0)
        begin n_bad++; $display("FAIL basic_busy[%0d]: got rdy %b done %b want 0/0", i, in_ready, done); end
      @(negedge clk);
    end
    n_cmp++; if (done !== 1'b1 || count !== 4'd4) begin n_bad++; $display("FAIL basic_done: got %b/%0d want 1/4", done, count); end
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_finish: got vld %b rdy %b want 0/0", out_valid, in_ready); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || count !== 4'd0 || in_ready !== 1'b1)
      begin n_bad++; $display("FAIL basic_idle: got done %b cnt %0d rdy %b want 0/0/1", done, count, in_ready); end
  endtask

  task automatic test_zero();
    in_valid = 1; in_data = 8'h00; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL zero_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (done !== 1'b1 || count !== 4'd0) begin n_bad++; $display("FAIL zero_done: got %b/%0d want 1/0", done, count); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL zero_rdy_finish: got %b want 0", in_ready); end
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1 || done !== 1'b0 || out_valid !== 1'b0)
      begin n_bad++; $display("FAIL zero_idle: got rdy %b done %b vld %b want 1/0/0", in_ready, done, out_valid); end
  endtask

  task automatic test_stall();
    in_valid = 1; in_data = 8'hFF; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    for (int i = 0; i < 8; i++) begin
      out_ready = 0;
      n_cmp++; if (out_valid !== 1'b1 || out_index !== 3'(i) || out_last !== (i == 7))
        begin n_bad++; $display("FAIL stall_pre[%0d]: got vld %b idx %0d last %b want 1/%0d/%b", i, out_valid, out_index, out_last, i, (i == 7)); end
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_index !== 3'(i) || out_last !== (i == 7))
        begin n_bad++; $display("FAIL stall_hold[%0d]: got vld %b idx %0d last %b want 1/%0d/%b", i, out_valid, out_index, out_last, i, (i == 7)); end
      out_ready = 1;
      @(negedge clk);
    end
    n_cmp++; if (done !== 1'b1 || count !== 4'd8) begin n_bad++; $display("FAIL stall_done: got %b/%0d want 1/8", done, count); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    in_valid = 1; in_data = 8'h80; out_ready = 1;
    @(negedge clk);
    in_data = 8'h01;
    n_cmp++; if (out_valid !== 1'b1 || out_index !== 3'd7 || out_last !== 1'b1)
      begin n_bad++; $display("FAIL b2b_top: got vld %b idx %0d last %b want 1/7/1", out_valid, out_index, out_last); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b1 || count !== 4'd1 || in_ready !== 1'b0)
      begin n_bad++; $display("FAIL b2b_done1: got done %b cnt %0d rdy %b want 1/1/0", done, count, in_ready); end
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin n_bad++; $display("FAIL b2b_idle: got rdy %b vld %b want 1/0", in_ready, out_valid); end
    @(negedge clk);
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b1 || out_index !== 3'd0 || out_last !== 1'b1)
      begin n_bad++; $display("FAIL b2b_second: got vld %b idx %0d last %b want 1/0/1", out_valid, out_index, out_last); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b1 || count !== 4'd1) begin n_bad++; $display("FAIL b2b_done2: got %b/%0d want 1/1", done, count); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    in_valid = 1; in_data = 8'b0011_1000; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    n_cmp++; if (out_index !== 3'd3) begin n_bad++; $display("FAIL rmid_first: got %0d want 3", out_index); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_index !== 3'd4) begin n_bad++; $display("FAIL rmid_second: got vld %b idx %0d want 1/4", out_valid, out_index); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_index !== 3'd0)
      begin n_bad++; $display("FAIL rmid_after: got vld %b rdy %b idx %0d want 0/1/0", out_valid, in_ready, out_index); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (done !== 1'b0 || count !== 4'd0) begin n_bad++; $display("FAIL rmid_nodone[%0d]: got %b/%0d want 0/0", i, done, count); end
      @(negedge clk);
    end
    in_valid = 1; in_data = 8'h02;
    @(negedge clk);
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b1 || out_index !== 3'd1 || out_last !== 1'b1)
      begin n_bad++; $display("FAIL rmid_new: got vld %b idx %0d last %b want 1/1/1", out_valid, out_index, out_last); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b1 || count !== 4'd1) begin n_bad++; $display("FAIL rmid_done: got %b/%0d want 1/1", done, count); end
    @(negedge clk);
  endtask

  task automatic test_width5();
    in_valid5 = 1; in_data5 = 5'b10001; out_ready5 = 1;
    @(negedge clk);
    in_valid5 = 0;
    n_cmp++; if (out_valid5 !== 1'b1 || out_index5 !== 3'd0 || out_last5 !== 1'b0)
      begin n_bad++; $display("FAIL w5_idx0: got vld %b idx %0d last %b want 1/0/0", out_valid5, out_index5, out_last5); end
    @(negedge clk);
    n_cmp++; if (out_valid5 !== 1'b1 || out_index5 !== 3'd4 || out_last5 !== 1'b1)
      begin n_bad++; $display("FAIL w5_idx4: got vld %b idx %0d last %b want 1/4/1", out_valid5, out_index5, out_last5); end
    @(negedge clk);
    n_cmp++; if (done5 !== 1'b1 || count5 !== 4'd2) begin n_bad++; $display("FAIL w5_done: got %b/%0d want 1/2", done5, count5); end
    @(negedge clk);
    n_cmp++; if (in_ready5 !== 1'b1 || done5 !== 1'b0) begin n_bad++; $display("FAIL w5_idle: got rdy %b done %b want 1/0", in_ready5, done5); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_width5();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
